// File: rtl/cpu_run_ctrl_pkg.sv
// Shared definitions for the run controller: state encoding and syscall codes.
package ctrl_run_pkg;

    // Controller states; the encoding is fixed so board debug can decode it.
    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_STEP_WAIT = 2'd1,
        ST_HALT      = 2'd2
    } run_state_e;

    // $v0 values recognised by SYSCALL.
    localparam logic [31:0] HALT_CODE = 32'd10;
    localparam logic [31:0] DISP_CODE = 32'd34;

endpackage

// File: rtl/cpu_run_ctrl_if.sv
// Bundle of decoder/register-file inputs and commit/display/statistics outputs
// of the run controller. The master side drives the datapath inputs; the slave
// side (the controller) drives the commit gate, display and counters.
interface cpu_run_ctrl_if
    import ctrl_run_pkg::*;
#(
    parameter int CW = 32
);
    logic          go;
    logic          step_mode;
    logic          step;
    logic          syscall;
    logic          jmp_any;
    logic          br_taken;
    logic [31:0]   v0;
    logic [31:0]   a0;
    logic          pc_en;
    logic          halted;
    logic [31:0]   disp_data;
    logic          disp_valid;
    logic [CW-1:0] ins_cnt;
    logic [CW-1:0] jmp_cnt;
    logic [CW-1:0] br_cnt;
    run_state_e    state;

    modport master (
        output go, step_mode, step, syscall, jmp_any, br_taken, v0, a0,
        input  pc_en, halted, disp_data, disp_valid, ins_cnt, jmp_cnt, br_cnt,
        input  state
    );

    modport slave (
        input  go, step_mode, step, syscall, jmp_any, br_taken, v0, a0,
        output pc_en, halted, disp_data, disp_valid, ins_cnt, jmp_cnt, br_cnt,
        output state
    );
endinterface

// File: rtl/cpu_run_ctrl_sat_counter.sv
// Up counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] q
);
    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    // Next count: advance only when requested and not already saturated.
    always_comb begin
        q_d = q_q;
        if (inc && (q_q != {W{1'b1}})) begin
            q_d = q_q + {{(W-1){1'b0}}, 1'b1};
        end
    end

    // Count register with synchronous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;
endmodule

// File: rtl/cpu_run_ctrl.sv
// Run controller for the single-cycle MIPS datapath: gates each instruction's
// commit through pc_en, handles halt/display syscalls, single-step and resume,
// and keeps saturating statistics for the board display.
module cpu_run_ctrl
    import ctrl_run_pkg::*;
#(
    parameter int          CW        = 32,
    parameter logic [31:0] HALT_CODE = ctrl_run_pkg::HALT_CODE,
    parameter logic [31:0] DISP_CODE = ctrl_run_pkg::DISP_CODE
) (
    input  logic           clk,
    input  logic           rst,
    cpu_run_ctrl_if.slave  bus
);
    run_state_e  state_q, state_d;
    logic        halted_q, halted_d;
    logic [31:0] disp_data_q, disp_data_d;
    logic        disp_valid_q, disp_valid_d;
    logic        commit_req;
    logic        halt_hit;
    logic        pc_en;
    logic        disp_hit;

    // A halting syscall is only recognised outside HALT so that the resume
    // commit with go can step past the same syscall the PC is parked on.
    assign halt_hit = bus.syscall && (bus.v0 == HALT_CODE) && (state_q != ST_HALT);
    assign pc_en    = !rst && commit_req && !halt_hit;
    assign disp_hit = pc_en && bus.syscall && (bus.v0 == DISP_CODE);

    // Commit request, next state and registered-output next values.
    always_comb begin
        commit_req   = 1'b0;
        state_d      = state_q;
        disp_data_d  = disp_data_q;
        disp_valid_d = 1'b0;
        case (state_q)
            ST_RUN: begin
                commit_req = 1'b1;
                if (halt_hit) begin
                    state_d = ST_HALT;
                end else if (bus.step_mode) begin
                    state_d = ST_STEP_WAIT;
                end
            end
            ST_STEP_WAIT: begin
                commit_req = bus.step;
                if (bus.step && halt_hit) begin
                    state_d = ST_HALT;
                end else if (!bus.step_mode) begin
                    state_d = ST_RUN;
                end
            end
            ST_HALT: begin
                commit_req = bus.go;
                if (bus.go) begin
                    state_d = bus.step_mode ? ST_STEP_WAIT : ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
        halted_d = (state_d == ST_HALT);
        if (disp_hit) begin
            disp_data_d  = bus.a0;
            disp_valid_d = 1'b1;
        end
    end

    // State and display registers; reset overrides every other update.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_RUN;
            halted_q     <= 1'b0;
            disp_data_q  <= '0;
            disp_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            halted_q     <= halted_d;
            disp_data_q  <= disp_data_d;
            disp_valid_q <= disp_valid_d;
        end
    end

    sat_counter #(.W(CW)) u_ins_cnt (
        .clk (clk),
        .rst (rst),
        .inc (pc_en),
        .q   (bus.ins_cnt)
    );

    sat_counter #(.W(CW)) u_jmp_cnt (
        .clk (clk),
        .rst (rst),
        .inc (pc_en && bus.jmp_any),
        .q   (bus.jmp_cnt)
    );

    sat_counter #(.W(CW)) u_br_cnt (
        .clk (clk),
        .rst (rst),
        .inc (pc_en && bus.br_taken),
        .q   (bus.br_cnt)
    );

    assign bus.pc_en      = pc_en;
    assign bus.halted     = halted_q;
    assign bus.disp_data  = disp_data_q;
    assign bus.disp_valid = disp_valid_q;
    assign bus.state      = state_q;
endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl: a full-width instance walks through run,
// halt/resume, display, single-step and reset; a 4-bit instance runs freely
// with br_taken held high to show saturation.
module tb_cpu_run_ctrl;
    import ctrl_run_pkg::*;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    cpu_run_ctrl_if #(.CW(32)) bus ();
    cpu_run_ctrl_if #(.CW(4))  sbus ();

    cpu_run_ctrl #(.CW(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    cpu_run_ctrl #(.CW(4)) dut_small (
        .clk (clk),
        .rst (rst),
        .bus (sbus)
    );

    // Clock and reset.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point for the whole bench.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one cycle; inputs are changed 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle after an input change.
    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        bus.go       = 1'b0;
        bus.step     = 1'b0;
        bus.syscall  = 1'b0;
        bus.jmp_any  = 1'b0;
        bus.br_taken = 1'b0;
        bus.v0       = 32'd0;
        bus.a0       = 32'd0;
    endtask

    task automatic check_counts(input string tag, input int ins, input int jmp, input int br);
        check({tag, "_ins"}, bus.ins_cnt, ins);
        check({tag, "_jmp"}, bus.jmp_cnt, jmp);
        check({tag, "_br"},  bus.br_cnt,  br);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        bus.step_mode = 1'b0;
        idle_inputs();
        sbus.go = 1'b0; sbus.step_mode = 1'b0; sbus.step = 1'b0; sbus.syscall = 1'b0;
        sbus.jmp_any = 1'b0; sbus.br_taken = 1'b1; sbus.v0 = 32'd0; sbus.a0 = 32'd0;

        // Reset state.
        tick();
        settle();
        check("rst_pc_en", bus.pc_en, 1'b0);
        tick();
        check("rst_halted", bus.halted, 1'b0);
        check("rst_disp_data", bus.disp_data, 32'd0);
        check("rst_disp_valid", bus.disp_valid, 1'b0);
        check("rst_state", bus.state, ST_RUN);
        check_counts("rst", 0, 0, 0);

        // 1: free run, five plain instructions.
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            settle();
            check("run_pc_en", bus.pc_en, 1'b1);
            tick();
        end
        check_counts("run5", 5, 0, 0);
        check("run5_halted", bus.halted, 1'b0);
        check("small_ins5", sbus.ins_cnt, 4'd5);

        // 2: halting syscall, wait in HALT, resume with go.
        bus.syscall = 1'b1; bus.v0 = 32'd10;
        settle();
        check("halt_pc_en", bus.pc_en, 1'b0);
        tick();
        check("halt_halted", bus.halted, 1'b1);
        check("halt_state", bus.state, ST_HALT);
        check("halt_ins", bus.ins_cnt, 32'd5);
        settle();
        check("halt_wait_pc_en", bus.pc_en, 1'b0);
        tick();
        check("halt_wait_halted", bus.halted, 1'b1);
        bus.go = 1'b1;
        settle();
        check("go_pc_en", bus.pc_en, 1'b1);
        tick();
        idle_inputs();
        check("go_halted", bus.halted, 1'b0);
        check("go_state", bus.state, ST_RUN);
        check("go_ins", bus.ins_cnt, 32'd6);

        // 3: display syscall.
        bus.syscall = 1'b1; bus.v0 = 32'd34; bus.a0 = 32'hDEADBEEF;
        settle();
        check("disp_pc_en", bus.pc_en, 1'b1);
        tick();
        idle_inputs();
        check("disp_data", bus.disp_data, 32'hDEADBEEF);
        check("disp_valid", bus.disp_valid, 1'b1);
        check("disp_halted", bus.halted, 1'b0);
        check("disp_ins", bus.ins_cnt, 32'd7);
        tick();
        check("disp_valid_drop", bus.disp_valid, 1'b0);
        check("disp_data_hold", bus.disp_data, 32'hDEADBEEF);
        check("disp_ins2", bus.ins_cnt, 32'd8);

        // 4: single step.
        bus.step_mode = 1'b1;
        settle();
        check("sm_enter_pc_en", bus.pc_en, 1'b1);
        tick();
        check("sm_state", bus.state, ST_STEP_WAIT);
        check("sm_ins", bus.ins_cnt, 32'd9);
        for (int i = 0; i < 10; i++) begin
            settle();
            check("sm_idle_pc_en", bus.pc_en, 1'b0);
            tick();
        end
        check("sm_idle_ins", bus.ins_cnt, 32'd9);
        bus.jmp_any = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.step = 1'b1;
            settle();
            check("step_pc_en", bus.pc_en, 1'b1);
            tick();
            bus.step = 1'b0;
            settle();
            check("step_gap_pc_en", bus.pc_en, 1'b0);
            tick();
        end
        bus.jmp_any = 1'b0;
        check_counts("step3", 12, 3, 0);

        // Halting syscall in STEP_WAIT needs a step to take effect.
        bus.syscall = 1'b1; bus.v0 = 32'd10;
        tick();
        check("sw_halt_nostep_halted", bus.halted, 1'b0);
        check("sw_halt_nostep_state", bus.state, ST_STEP_WAIT);
        bus.step = 1'b1;
        settle();
        check("sw_halt_step_pc_en", bus.pc_en, 1'b0);
        tick();
        bus.step = 1'b0;
        check("sw_halt_halted", bus.halted, 1'b1);
        check("sw_halt_ins", bus.ins_cnt, 32'd12);

        // 5a: go and step together in HALT with step_mode=1.
        bus.go = 1'b1; bus.step = 1'b1;
        settle();
        check("gostep_pc_en", bus.pc_en, 1'b1);
        tick();
        idle_inputs();
        check("gostep_state", bus.state, ST_STEP_WAIT);
        check("gostep_halted", bus.halted, 1'b0);
        check("gostep_ins", bus.ins_cnt, 32'd13);

        // Leave step mode, then one taken branch in RUN.
        bus.step_mode = 1'b0;
        settle();
        check("sm_exit_pc_en", bus.pc_en, 1'b0);
        tick();
        check("sm_exit_state", bus.state, ST_RUN);
        bus.br_taken = 1'b1;
        settle();
        check("br_pc_en", bus.pc_en, 1'b1);
        tick();
        bus.br_taken = 1'b0;
        check_counts("br", 14, 3, 1);

        // 5b: 4-bit instance has committed well over 15 taken branches.
        check("small_ins_sat", sbus.ins_cnt, 4'hF);
        check("small_br_sat", sbus.br_cnt, 4'hF);
        check("small_jmp", sbus.jmp_cnt, 4'h0);

        // 6: reset while halted.
        bus.syscall = 1'b1; bus.v0 = 32'd10;
        tick();
        check("pre_rst_halted", bus.halted, 1'b1);
        rst = 1'b1;
        idle_inputs();
        tick();
        rst = 1'b0;
        settle();
        check("post_rst_state", bus.state, ST_RUN);
        check("post_rst_halted", bus.halted, 1'b0);
        check("post_rst_disp_data", bus.disp_data, 32'd0);
        check_counts("post_rst", 0, 0, 0);
        check("post_rst_pc_en", bus.pc_en, 1'b1);
        tick();
        check("post_rst_ins", bus.ins_cnt, 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
